rom_read_arbiter: RTL and testbench

ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

---
 rtl/rom_read_arbiter.sv | 140 ++++++++++++++
 tb/tb_rom_read_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
// Two requesters share one combinational ROM through a 3-state FSM
// (IDLE -> READ -> RESP). Each transaction takes 3 cycles, and its latency is fixed.
//
// Handshake: a requester raises mN_req with a stable mN_addr and holds both
// until it sees the one-cycle mN_gnt pulse. If mN_req is still high in the
// IDLE cycle after that requester's response, it counts as a new request.
// One cycle after the grant, mN_rvalid pulses once, with mN_rdata/mN_err.
// mN_err is only meaningful while mN_rvalid is high. If both requesters
// ask at once, the one not served last wins (round-robin).
//
// Optional feature: define ROM_ARB_RANGE_CHECK_EN to flag reads whose
// address lies above ROM_BYTES-4. Such a read returns err=1 and rdata=0,
// and it never drives rom_addr.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   m0_req, m0_addr      requester 0 request and byte address
//   m0_gnt, m0_rvalid    requester 0 grant pulse and response pulse
//   m0_rdata, m0_err     requester 0 big-endian read word and range fault
//   m1_*                 the same signals for requester 1
//   rom_addr, rom_data   byte address to the ROM, and the word it returns
//   dbg_state            current FSM state (0 IDLE, 1 READ, 2 RESP)
module rom_read_arbiter #(
  parameter int ROM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  // Highest legal word address; it is used only when range checking is enabled.
  localparam logic [31:0] MAX_ADDR = 32'(ROM_BYTES - 4);

  state_t      state;
  logic        last_served;  // id of the requester granted most recently
  logic        cur_id;       // id of the transaction in flight
  logic        cur_oor;      // the transaction in flight is out of range

  logic        win_id;
  logic [31:0] win_addr;
  logic        win_oor;

  // Requester 1 wins when it asks alone, or when both ask and m0 went last.
  always_comb begin
    win_id   = 1'b0;
    win_addr = m0_addr;
    if (m1_req && (!m0_req || !last_served)) begin
      win_id   = 1'b1;
      win_addr = m1_addr;
    end
  end

`ifdef ROM_ARB_RANGE_CHECK_EN
  assign win_oor = (win_addr > MAX_ADDR);
`else
  logic unused_max_addr;
  assign unused_max_addr = ^MAX_ADDR;
  assign win_oor         = 1'b0;
`endif

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      cur_id      <= 1'b0;
      cur_oor     <= 1'b0;
      m0_gnt      <= 1'b0;
      m0_rvalid   <= 1'b0;
      m0_rdata    <= 32'd0;
      m0_err      <= 1'b0;
      m1_gnt      <= 1'b0;
      m1_rvalid   <= 1'b0;
      m1_rdata    <= 32'd0;
      m1_err      <= 1'b0;
      rom_addr    <= 32'd0;
    end else begin
      // Grants and responses are single-cycle pulses by default.
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state       <= READ;
            cur_id      <= win_id;
            last_served <= win_id;
            cur_oor     <= win_oor;
            // An out-of-range read leaves the ROM address where it was.
            if (!win_oor) rom_addr <= win_addr;
            if (win_id) m1_gnt <= 1'b1;
            else        m0_gnt <= 1'b1;
          end
        end
        READ: begin
          state <= RESP;
          if (cur_id) begin
            m1_rvalid <= 1'b1;
            m1_rdata  <= cur_oor ? 32'd0 : rom_data;
            m1_err    <= cur_oor;
          end else begin
            m0_rvalid <= 1'b1;
            m0_rdata  <= cur_oor ? 32'd0 : rom_data;
            m0_err    <= cur_oor;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter. The bench holds a 4 KiB byte ROM
// model in which byte i = (3*i+1) mod 256, except bytes 0x10..0x13, which
// hold 11 22 33 44. Inputs are driven, and outputs sampled, 1 time unit
// after each rising edge.
module tb_rom_read_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0;
  logic [31:0] m0_addr = 32'd0;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0;
  logic [31:0] m1_addr = 32'd0;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rom_mem [0:4095];
  logic [11:0] ra;

  always #5 clk = ~clk;

  assign ra       = rom_addr[11:0];
  assign rom_data = {rom_mem[ra], rom_mem[ra + 12'd1], rom_mem[ra + 12'd2], rom_mem[ra + 12'd3]};

  rom_read_arbiter #(.ROM_BYTES(4096)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .rom_addr(rom_addr), .rom_data(rom_data), .dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flag vector used below: {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}.
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err});
    end
    total++;
    if ({m0_rdata, m1_rdata, rom_addr} !== 96'd0) begin
      bad++; $display("FAIL reset_data: got %h %h %h want zeros", m0_rdata, m1_rdata, rom_addr);
    end
    total++;
    if (dbg_state !== 2'd0) begin
      bad++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_m0();
    m0_req = 1'b1; m0_addr = 32'h10;
    step();
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b1000) begin
      bad++; $display("FAIL single_gnt: got %b want 1000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
    end
    total++;
    if (rom_addr !== 32'h10) begin
      bad++; $display("FAIL single_rom_addr: got %h want 00000010", rom_addr);
    end
    m0_req = 1'b0;
    step();
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0010) begin
      bad++; $display("FAIL single_rvalid: got %b want 0010", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
    end
    total++;
    if (m0_rdata !== 32'h11223344 || m0_err !== 1'b0) begin
      bad++; $display("FAIL single_data: got %h err %b want 11223344 err 0", m0_rdata, m0_err);
    end
    step();
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL single_idle: got %b state %0d want 0000 state 0", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, dbg_state);
    end
  endtask

  task automatic test_both_round_robin();
    logic [31:0] exp_data, exp_other;
    rst = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h20;
    m1_req = 1'b1; m1_addr = 32'h40;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_data  = (k % 2 == 1) ? 32'hC1C4C7CA : 32'h6164676A;
      exp_other = (k == 0) ? 32'd0 : ((k % 2 == 1) ? 32'h6164676A : 32'hC1C4C7CA);
      step();
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== ((k % 2 == 1) ? 4'b0100 : 4'b1000)) begin
        bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, (k % 2 == 1) ? 4'b0100 : 4'b1000);
      end
      step();
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== ((k % 2 == 1) ? 4'b0001 : 4'b0010)) begin
        bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, (k % 2 == 1) ? 4'b0001 : 4'b0010);
      end
      total++;
      if (((k % 2 == 1) ? m1_rdata : m0_rdata) !== exp_data) begin
        bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, (k % 2 == 1) ? m1_rdata : m0_rdata, exp_data);
      end
      total++;
      if (((k % 2 == 1) ? m0_rdata : m1_rdata) !== exp_other) begin
        bad++; $display("FAIL rr_hold[%0d]: got %h want %h", k, (k % 2 == 1) ? m0_rdata : m1_rdata, exp_other);
      end
      if (k == 3) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
      step();
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin
        bad++; $display("FAIL rr_idle[%0d]: got %b want 0000", k, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
      end
    end
  endtask

  task automatic test_unaligned_m1();
    m1_req = 1'b1; m1_addr = 32'h3;
    step();
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0100 || rom_addr !== 32'h3) begin
      bad++; $display("FAIL unaligned_gnt: got %b addr %h want 0100 addr 00000003", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, rom_addr);
    end
    m1_req = 1'b0;
    step();
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0001 || m1_rdata !== 32'h0A0D1013 || m1_err !== 1'b0) begin
      bad++; $display("FAIL unaligned_data: got %b %h err %b want 0001 0a0d1013 err 0", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, m1_rdata, m1_err);
    end
    step();
  endtask

  task automatic test_top_word();
    m0_req = 1'b1; m0_addr = 32'hFFC;
    step();
    total++;
    if (m0_gnt !== 1'b1 || rom_addr !== 32'hFFC) begin
      bad++; $display("FAIL top_gnt: got gnt %b addr %h want gnt 1 addr 00000ffc", m0_gnt, rom_addr);
    end
    m0_req = 1'b0;
    step();
    total++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hF5F8FBFE || m0_err !== 1'b0) begin
      bad++; $display("FAIL top_data: got v %b %h err %b want v 1 f5f8fbfe err 0", m0_rvalid, m0_rdata, m0_err);
    end
    step();
  endtask

  task automatic test_range();
    logic [31:0] exp_addr, exp_data;
    logic        exp_err;
`ifdef ROM_ARB_RANGE_CHECK_EN
    exp_addr = 32'hFFC; exp_data = 32'd0; exp_err = 1'b1;
`else
    exp_addr = 32'hFFD; exp_data = 32'hF8FBFE01; exp_err = 1'b0;
`endif
    m0_req = 1'b1; m0_addr = 32'hFFD;
    step();
    total++;
    if (m0_gnt !== 1'b1 || rom_addr !== exp_addr) begin
      bad++; $display("FAIL range_gnt: got gnt %b addr %h want gnt 1 addr %h", m0_gnt, rom_addr, exp_addr);
    end
    m0_req = 1'b0;
    step();
    total++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== exp_data || m0_err !== exp_err) begin
      bad++; $display("FAIL range_data: got v %b %h err %b want v 1 %h err %b", m0_rvalid, m0_rdata, m0_err, exp_data, exp_err);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    m1_req = 1'b1; m1_addr = 32'h8;
    step();
    total++;
    if (m1_gnt !== 1'b1 || dbg_state !== 2'd1) begin
      bad++; $display("FAIL midrst_gnt: got gnt %b state %0d want gnt 1 state 1", m1_gnt, dbg_state);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 6'b0 || {m0_rdata, m1_rdata, rom_addr} !== 96'd0) begin
      bad++; $display("FAIL midrst_outputs: got %b %h %h %h want zeros", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err}, m0_rdata, m1_rdata, rom_addr);
    end
    step();
    total++;
    if (m1_rvalid !== 1'b0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL midrst_norvalid: got rvalid %b state %0d want rvalid 0 state 0", m1_rvalid, dbg_state);
    end
    rst = 1'b0;
    step();
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0100 || rom_addr !== 32'h8) begin
      bad++; $display("FAIL midrst_regrant: got %b addr %h want 0100 addr 00000008", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, rom_addr);
    end
    m1_req = 1'b0;
    step();
    total++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h191C1F22) begin
      bad++; $display("FAIL midrst_data: got v %b %h want v 1 191c1f22", m1_rvalid, m1_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    m0_req = 1'b1; m0_addr = 32'h30;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       exp_data = 32'h9194979A;
        1:       exp_data = 32'h9DA0A3A6;
        default: exp_data = 32'hA9ACAFB2;
      endcase
      step();
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b1000) begin
        bad++; $display("FAIL b2b_gnt[%0d]: got %b want 1000", k, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
      end
      m0_addr = 32'h30 + 32'(4 * (k + 1));
      step();
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0010 || m0_rdata !== exp_data) begin
        bad++; $display("FAIL b2b_data[%0d]: got %b %h want 0010 %h", k, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, m0_rdata, exp_data);
      end
      if (k == 2) m0_req = 1'b0;
      step();
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin
        bad++; $display("FAIL b2b_idle[%0d]: got %b want 0000", k, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'(i * 3 + 1);
    rom_mem[16'h10] = 8'h11;
    rom_mem[16'h11] = 8'h22;
    rom_mem[16'h12] = 8'h33;
    rom_mem[16'h13] = 8'h44;

    test_reset();
    test_single_m0();
    test_both_round_robin();
    test_unaligned_m1();
    test_top_word();
    test_range();
    test_reset_mid_read();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
